// File: rtl/dvp_capture_ctrl.sv
// DVP camera capture front-end: pixel assembly, crop window, frame decimation and short-frame detection.
// Optional build macro DVP_CAPTURE_BGR_SWAP_EN swaps the RGB565 R and B fields of the assembled pixel.
module dvp_capture_ctrl #(
    parameter int DATA_W      = 8,
    parameter int PIX_BYTES   = 2,
    parameter int CNT_W       = 12,
    parameter int SKIP_FRAMES = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vsync_i,
    input  logic                          href_i,
    input  logic [DATA_W-1:0]             pdata_i,
    input  logic [CNT_W-1:0]              win_x0,
    input  logic [CNT_W-1:0]              win_w,
    input  logic [CNT_W-1:0]              win_y0,
    input  logic [CNT_W-1:0]              win_h,
    input  logic [1:0]                    decim,
    output logic [DATA_W*PIX_BYTES-1:0]   pix_o,
    output logic                          pix_we_o,
    output logic                          frame_start_o,
    output logic                          running_o,
    output logic [15:0]                   frame_cnt_o,
    output logic                          err_short_o
);

    localparam int PIX_W  = DATA_W * PIX_BYTES;
    localparam int SKIP_W = $clog2(SKIP_FRAMES + 1);
    localparam int CW1    = CNT_W + 1;

    typedef enum logic [1:0] {SKIP, ARM, ACTIVE} state_t;

    state_t             state_q, state_d;
    logic               vsync_r, vsync_d, href_r, href_d;
    logic [DATA_W-1:0]  pdata_r;
    logic [1:0]         beat_q;
    logic [PIX_W-1:0]   asm_q;
    logic [CNT_W-1:0]   x_q, y_q;
    logic [SKIP_W-1:0]  skip_q;
    logic [2:0]         decim_q;
    logic [CNT_W-1:0]   sh_x0, sh_w, sh_y0, sh_h;
    logic [CW1-1:0]     lines_q;
    logic               line_hit_q;

    logic               vsync_rise, href_fall, beat_valid, pix_done, in_x, in_y, hit;
    logic               dec_ok, enter_active, short_set;
    logic [2:0]         dec_mask;
    logic [CW1-1:0]     lines_total;
    logic [PIX_W-1:0]   word, pix_word;

    assign vsync_rise  = vsync_r & ~vsync_d;
    assign href_fall   = href_d & ~href_r;
    // Bytes arriving while VSYNC is high belong to no line and are dropped.
    assign beat_valid  = href_r & ~vsync_r;
    assign pix_done    = beat_valid && (beat_q == 2'(PIX_BYTES - 1));
    assign word        = (asm_q << DATA_W) | PIX_W'(pdata_r);

    assign in_x = ({1'b0, x_q} >= {1'b0, sh_x0}) && ({1'b0, x_q} < ({1'b0, sh_x0} + {1'b0, sh_w}));
    assign in_y = ({1'b0, y_q} >= {1'b0, sh_y0}) && ({1'b0, y_q} < ({1'b0, sh_y0} + {1'b0, sh_h}));
    assign hit  = pix_done && (state_q == ACTIVE) && in_x && in_y;

    assign dec_mask    = 3'((4'd1 << decim) - 4'd1);
    assign dec_ok      = (decim_q & dec_mask) == 3'd0;
    // A line cut short by VSYNC still counts if it already produced an in-window pixel.
    assign lines_total = lines_q + CW1'(line_hit_q);

`ifdef DVP_CAPTURE_BGR_SWAP_EN
    if (!(DATA_W == 8 && PIX_BYTES == 2)) begin : g_bad_swap_cfg
        $error("DVP_CAPTURE_BGR_SWAP_EN requires DATA_W=8 and PIX_BYTES=2");
    end
    assign pix_word = {word[4:0], word[10:5], word[15:11]};
`else
    assign pix_word = word;
`endif

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch appears.
    always_comb begin
        state_d      = state_q;
        enter_active = 1'b0;
        short_set    = 1'b0;
        case (state_q)
            SKIP: begin
                if (vsync_rise && skip_q == SKIP_W'(SKIP_FRAMES - 1)) state_d = ARM;
            end
            ARM: begin
                if (vsync_rise && dec_ok) begin
                    state_d      = ACTIVE;
                    enter_active = 1'b1;
                end
            end
            ACTIVE: begin
                if (vsync_rise) begin
                    short_set = lines_total < {1'b0, sh_h};
                    if (dec_ok) enter_active = 1'b1;
                    else        state_d      = ARM;
                end
            end
            default: state_d = SKIP;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= SKIP;
            vsync_r       <= 1'b0;
            vsync_d       <= 1'b0;
            href_r        <= 1'b0;
            href_d        <= 1'b0;
            pdata_r       <= '0;
            beat_q        <= '0;
            asm_q         <= '0;
            x_q           <= '0;
            y_q           <= '0;
            skip_q        <= '0;
            decim_q       <= '0;
            sh_x0         <= '0;
            sh_w          <= '0;
            sh_y0         <= '0;
            sh_h          <= '0;
            lines_q       <= '0;
            line_hit_q    <= 1'b0;
            pix_o         <= '0;
            pix_we_o      <= 1'b0;
            frame_start_o <= 1'b0;
            running_o     <= 1'b0;
            frame_cnt_o   <= '0;
            err_short_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_r <= vsync_i;
            vsync_d <= vsync_r;
            href_r  <= href_i;
            href_d  <= href_r;
            pdata_r <= pdata_i;

            if (!beat_valid) begin
                beat_q <= '0;
            end else begin
                asm_q  <= word;
                beat_q <= pix_done ? 2'd0 : beat_q + 2'd1;
            end

            if (href_fall)     x_q <= '0;
            else if (pix_done) x_q <= x_q + CNT_W'(1);

            if (vsync_rise)     y_q <= '0;
            else if (href_fall) y_q <= y_q + CNT_W'(1);

            if (state_q == SKIP && vsync_rise) skip_q <= skip_q + SKIP_W'(1);
            if (state_q != SKIP && vsync_rise) decim_q <= decim_q + 3'd1;
            if (state_q == SKIP && state_d == ARM) running_o <= 1'b1;

            frame_start_o <= enter_active;
            if (enter_active) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
                sh_x0       <= win_x0;
                sh_w        <= win_w;
                sh_y0       <= win_y0;
                sh_h        <= win_h;
            end

            if (vsync_rise)                   lines_q <= '0;
            else if (href_fall && line_hit_q) lines_q <= lines_q + CW1'(1);

            if (vsync_rise || href_fall) line_hit_q <= 1'b0;
            else if (hit)                line_hit_q <= 1'b1;

            if (short_set) err_short_o <= 1'b1;

            pix_we_o <= hit;
            if (hit) pix_o <= pix_word;
        end
    end

endmodule

// File: tb/tb_dvp_capture_ctrl.sv
// Directed bench for dvp_capture_ctrl: 8 px x N line frames with pixel (x,y) = {8'hA0|x, 8'hB0|y}.
module tb_dvp_capture_ctrl;

    localparam int DATA_W = 8;
    localparam int PIX_BYTES = 2;
    localparam int CNT_W = 12;
    localparam int SKIP = 4;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        vsync_i, href_i;
    logic [DATA_W-1:0]           pdata_i;
    logic [CNT_W-1:0]            win_x0, win_w, win_y0, win_h;
    logic [1:0]                  decim;
    logic [DATA_W*PIX_BYTES-1:0] pix_o;
    logic                        pix_we_o, frame_start_o, running_o, err_short_o;
    logic [15:0]                 frame_cnt_o;

    dvp_capture_ctrl #(
        .DATA_W(DATA_W), .PIX_BYTES(PIX_BYTES), .CNT_W(CNT_W), .SKIP_FRAMES(SKIP)
    ) dut (
        .clk(clk), .rst(rst), .vsync_i(vsync_i), .href_i(href_i), .pdata_i(pdata_i),
        .win_x0(win_x0), .win_w(win_w), .win_y0(win_y0), .win_h(win_h), .decim(decim),
        .pix_o(pix_o), .pix_we_o(pix_we_o), .frame_start_o(frame_start_o),
        .running_o(running_o), .frame_cnt_o(frame_cnt_o), .err_short_o(err_short_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_we = 0;
    int n_fs = 0;
    int we_cyc = 0;
    int beat_cyc = 0;
    logic [15:0] pix_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pix_we_o) begin
            n_we++;
            pix_q.push_back(pix_o);
            we_cyc = cyc;
        end
        if (frame_start_o) n_fs++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_win(input int x0, input int w, input int y0, input int h);
        win_x0 = CNT_W'(x0);
        win_w  = CNT_W'(w);
        win_y0 = CNT_W'(y0);
        win_h  = CNT_W'(h);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pix"}, 32'(pix_o), 32'h0);
        check({tag, "_we"}, 32'(pix_we_o), 32'h0);
        check({tag, "_fs"}, 32'(frame_start_o), 32'h0);
        check({tag, "_run"}, 32'(running_o), 32'h0);
        check({tag, "_cnt"}, 32'(frame_cnt_o), 32'h0);
        check({tag, "_err"}, 32'(err_short_o), 32'h0);
    endtask

    // One frame: VSYNC pulse, then `lines` lines of 8 two-beat pixels. mid_en retargets the
    // window ports to full-frame after VSYNC falls; rst_line asserts rst at pixel 3 of that line.
    task automatic send_frame(input int lines, input bit mid_en, input int rst_line);
        repeat (4) begin
            @(negedge clk);
            vsync_i = 1'b1;
        end
        @(negedge clk);
        vsync_i = 1'b0;
        if (mid_en) set_win(0, 8, 0, 4);
        repeat (4) @(negedge clk);
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < 8; x++) begin
                @(negedge clk);
                if (y == rst_line && x == 3) begin
                    rst     = 1'b1;
                    href_i  = 1'b0;
                    pdata_i = '0;
                    return;
                end
                href_i  = 1'b1;
                pdata_i = 8'hA0 | 8'(x);
                @(negedge clk);
                pdata_i = 8'hB0 | 8'(y);
                if (x == 1 && y == 2) beat_cyc = cyc;
            end
            @(negedge clk);
            href_i  = 1'b0;
            pdata_i = '0;
            repeat (3) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        #1;
    endtask

    int base_we, base_fs, idx;
    logic [15:0] exp_pix;

    initial begin
        vsync_i = 1'b0;
        href_i  = 1'b0;
        pdata_i = '0;
        decim   = 2'd0;
        set_win(0, 8, 0, 4);
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Startup gate: four frames skipped, the fifth captured in full.
        repeat (3) send_frame(4, 1'b0, -1);
        check("t1_run_pre", 32'(running_o), 32'd0);
        send_frame(4, 1'b0, -1);
        check("t1_run", 32'(running_o), 32'd1);
        check("t1_we_skip", 32'(n_we), 32'd0);
        check("t1_fs_skip", 32'(n_fs), 32'd0);
        send_frame(4, 1'b0, -1);
        check("t1_fs", 32'(n_fs), 32'd1);
        check("t1_we", 32'(n_we), 32'd32);
        check("t1_cnt", 32'(frame_cnt_o), 32'd1);
        check("t1_pix_first", 32'(pix_q[0]), 32'hA0B0);
        check("t1_pix_last", 32'(pix_q[31]), 32'hA7B3);

        // Single-pixel window: value and two-cycle latency from the last beat.
        set_win(1, 1, 2, 1);
        base_we = n_we;
        send_frame(4, 1'b0, -1);
        check("t2_we", 32'(n_we - base_we), 32'd1);
        check("t2_pix", 32'(pix_q[base_we]), 32'hA1B2);
        check("t2_lat", 32'(we_cyc - beat_cyc), 32'd2);
        check("t2_cnt", 32'(frame_cnt_o), 32'd2);
        check("t2_err", 32'(err_short_o), 32'd0);

        // Crop window with a mid-frame port change that must not take effect.
        set_win(2, 3, 1, 2);
        base_we = n_we;
        send_frame(4, 1'b1, -1);
        check("t3_we", 32'(n_we - base_we), 32'd6);
        idx = base_we;
        for (int y = 1; y <= 2; y++) begin
            for (int x = 2; x <= 4; x++) begin
                exp_pix = {8'hA0 | 8'(x), 8'hB0 | 8'(y)};
                check("t3_pix", 32'(pix_q[idx]), 32'(exp_pix));
                idx++;
            end
        end
        base_we = n_we;
        send_frame(4, 1'b0, -1);
        check("t3_next_we", 32'(n_we - base_we), 32'd32);
        check("t3_err", 32'(err_short_o), 32'd0);

        // Short frame: 3 lines against win_h=4; error is sticky across good frames.
        base_we = n_we;
        send_frame(3, 1'b0, -1);
        check("t5_we", 32'(n_we - base_we), 32'd24);
        check("t5_err_pre", 32'(err_short_o), 32'd0);
        send_frame(4, 1'b0, -1);
        check("t5_err", 32'(err_short_o), 32'd1);
        send_frame(4, 1'b0, -1);
        check("t5_err_sticky", 32'(err_short_o), 32'd1);
        check("t5_cnt", 32'(frame_cnt_o), 32'd7);

        // Reset mid-line clears everything at once and restarts the skip delay.
        send_frame(4, 1'b0, 1);
        #1;
        check_all_zero("t6_rst");
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        decim = 2'd2;
        set_win(0, 8, 0, 4);
        base_we = n_we;
        base_fs = n_fs;
        repeat (3) send_frame(4, 1'b0, -1);
        check("t6_run_pre", 32'(running_o), 32'd0);
        send_frame(4, 1'b0, -1);
        check("t6_run", 32'(running_o), 32'd1);
        check("t6_we", 32'(n_we - base_we), 32'd0);
        check("t6_fs", 32'(n_fs - base_fs), 32'd0);

        // Decimation by 4: frames 0 and 4 of the next eight are captured.
        for (int i = 0; i < 8; i++) begin
            send_frame(4, 1'b0, -1);
            check($sformatf("t4_fs%0d", i), 32'(n_fs - base_fs), (i < 4) ? 32'd1 : 32'd2);
        end
        check("t4_cnt", 32'(frame_cnt_o), 32'd2);
        check("t4_we", 32'(n_we - base_we), 32'd64);
        check("t4_err", 32'(err_short_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
